// File: rtl/tsarb_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
// Optional build macro used by the top: TSARB_CONFLICT_CHECK_EN.
package tsarb_pkg;

    // Arbiter FSM states: no owner, undriven turnaround, pin owner driving.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } tsarb_state_e;

    // Bits needed to hold a counter that runs from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: starting just past the last owner and
// wrapping around, returns the first requester whose req bit is set.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);

    // Walk offsets 1..N_REQ from the last owner; the last owner itself is
    // visited last, so it only wins when nobody else is asking.
    always_comb begin
        int j;
        pick_oh    = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        j          = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last) + k) % N_REQ;
            if (!pick_valid && req[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(j);
                pick_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate pin group. Registers the pad output
// enable and output data, inserts undriven turnaround cycles between owners
// and returns the registered pin value to every requester.
// Optional build macro: TSARB_CONFLICT_CHECK_EN adds the sticky 'conflict'
// output and the pin readback compare behind it.
//
// Request/grant protocol: a requester holds req high for as long as it wants
// the pins; grant rises when its value is being driven (bus_out carries the
// data slice sampled on the previous edge) and stays high until the requester
// drops req or, when others are waiting, MAX_HOLD own cycles have elapsed.
// A dropped grant is final; the requester must win a new pick to drive again.
module tristate_bus_arbiter
    import tsarb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 2,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    input  logic [WIDTH-1:0]       bus_in,
    output logic [N_REQ-1:0]       grant,
    output logic [WIDTH-1:0]       bus_oe,
    output logic [WIDTH-1:0]       bus_out,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   busy,
    output tsarb_state_e           state_dbg
`ifdef TSARB_CONFLICT_CHECK_EN
    ,
    output logic                   conflict
`endif
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TURN_W = cnt_width(TURN_CYCLES);
    localparam int HOLD_W = cnt_width(MAX_HOLD);

    localparam logic [TURN_W-1:0] TURN_LOAD  = TURN_W'(TURN_CYCLES);
    localparam logic [TURN_W-1:0] TURN_LAST  = TURN_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MAX_HOLD);
    // The hold count includes the cycle in which ownership starts, so an
    // owner released by the limit drives for exactly MAX_HOLD cycles.
    localparam logic [HOLD_W-1:0] HOLD_FIRST = (MAX_HOLD != 0) ? HOLD_W'(1) : '0;
    localparam logic              HOLD_EN    = (MAX_HOLD != 0);

    tsarb_state_e      state_q, state_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [N_REQ-1:0]  pend_q, pend_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0]  oe_q, oe_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [WIDTH-1:0]  rd_q, rd_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [WIDTH-1:0]  owner_data;
    logic              owner_req;
    logic              others_pending;
    logic              release_own;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req),
        .last       (last_q),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // The pending/current owner is always the last picked requester.
    always_comb begin
        owner_data     = data[int'(last_q)*WIDTH +: WIDTH];
        owner_req      = |(req & pend_q);
        others_pending = |(req & ~pend_q);
        release_own    = !owner_req ||
                         (HOLD_EN && (hold_q == HOLD_MAX) && others_pending);
    end

    // Next-state and next-output computation for the IDLE/TURN/OWN FSM.
    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        hold_d  = hold_q;
        last_d  = last_q;
        pend_d  = pend_q;
        grant_d = grant_q;
        oe_d    = oe_q;
        out_d   = out_q;
        rd_d    = bus_in;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                oe_d    = '0;
                if (pick_valid) begin
                    last_d  = pick_idx;
                    pend_d  = pick_oh;
                    turn_d  = TURN_LOAD;
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                grant_d = '0;
                oe_d    = '0;
                turn_d  = turn_q - 1'b1;
                // Ownership starts even if the pending owner already dropped
                // req; it is then released on the first OWN edge.
                if (turn_q <= TURN_LAST) begin
                    turn_d  = '0;
                    state_d = ST_OWN;
                    grant_d = pend_q;
                    oe_d    = '1;
                    out_d   = owner_data;
                    hold_d  = HOLD_FIRST;
                end
            end
            ST_OWN: begin
                out_d = owner_data;
                if (HOLD_EN && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end
                if (release_own) begin
                    grant_d = '0;
                    oe_d    = '0;
                    out_d   = out_q;
                    hold_d  = '0;
                    if (pick_valid) begin
                        last_d  = pick_idx;
                        pend_d  = pick_oh;
                        turn_d  = TURN_LOAD;
                        state_d = ST_TURN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                oe_d    = '0;
            end
        endcase
    end

    // State and pad registers; reset drops the pad enables without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            turn_q  <= '0;
            hold_q  <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            pend_q  <= '0;
            grant_q <= '0;
            oe_q    <= '0;
            out_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            rd_q    <= rd_d;
        end
    end

`ifdef TSARB_CONFLICT_CHECK_EN
    logic first_q, first_d;
    logic conflict_q, conflict_d;

    // Readback compare: skip the first own cycle, where the pins may still be
    // settling from the undriven state; the flag is sticky until reset.
    always_comb begin
        first_d    = (state_q == ST_TURN) && (state_d == ST_OWN);
        conflict_d = conflict_q;
        if ((state_q == ST_OWN) && !first_q && (bus_in != out_q)) begin
            conflict_d = 1'b1;
        end
    end

    // Registers for the readback compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            first_q    <= first_d;
            conflict_q <= conflict_d;
        end
    end

    assign conflict = conflict_q;
`endif

    assign grant     = grant_q;
    assign bus_oe    = oe_q;
    assign bus_out   = out_q;
    assign rd_data   = rd_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule
